fetch_stage: RTL and testbench

Instruction-fetch stage between the PC register and the decode stage of the pipelined CPU. It consumes the current PC, computes the next PC that the PC register loads every cycle, issues reads to the synchronous instruction memory, and buffers returned instructions in a small queue. It presents them to decode through a valid/ready handshake, and handles stalls and branch/jump redirects without losing or duplicating instructions.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_queue.sv | 56 +++++
 rtl/fetch_stage.sv | 128 ++++++++++++
 tb/tb_fetch_stage.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch stage
package fetch_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam logic [31:0] PC_STEP  = 32'd4;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - circular instruction queue between fetch and decode
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int  DEPTH = 2,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear_i,
    input  logic          push_i,
    input  fetch_entry_t  push_data_i,
    input  logic          pop_i,
    output logic [CW-1:0] count_o,
    output fetch_entry_t  head_o
);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    logic [CW-1:0] count_q;

    // Storage, pointers and occupancy; slots reset to NOP so an empty head reads as a NOP at PC 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '{inst: NOP_INST, pc: 32'h0};
            end
        end else if (clear_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - fetch stage: next-PC, imem issue, in-flight tracking, decode queue (optional FETCH_BYPASS_EN)
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_i,
    output logic [31:0] next_pc_o,
    output logic        imem_en_o,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        id_ready_i,
    output logic        id_valid_o,
    output logic [31:0] id_inst_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_pc_plus4_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t  state_q, state_d;
    logic          run;
    logic          issue;
    logic          pop;
    logic          resp_valid;
    logic          q_push;
    logic          q_pop;
    logic          id_valid;
    logic          inflight_q;
    logic [31:0]   inflight_pc_q;
    logic [CW-1:0] count;
    logic [CW:0]   occupancy;
    fetch_entry_t  head;
    fetch_entry_t  resp;
    fetch_entry_t  id_entry;

    // FSM state register: BOOT mirrors the PC register's one-cycle hold after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= BOOT;
        else        state_q <= state_d;
    end

    // FSM next state: BOOT always advances to RUN after one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    // FSM outputs: fetching is only allowed in RUN.
    always_comb begin
        run = (state_q == RUN);
    end

    // Issue only when the returning word is guaranteed a queue slot.
    always_comb begin
        pop       = id_valid & id_ready_i;
        occupancy = (CW+1)'(count) + (CW+1)'(inflight_q) - (CW+1)'(pop);
        issue     = run & ~redirect_i & (occupancy < (CW+1)'(DEPTH));
    end

    // Next-PC priority: redirect, then sequential advance, else hold.
    always_comb begin
        next_pc_o = pc_i;
        if (redirect_i)  next_pc_o = redirect_pc_i;
        else if (issue)  next_pc_o = pc_i + PC_STEP;
    end

    assign imem_en_o   = issue;
    assign imem_addr_o = pc_i;

    // Remember whether a read is outstanding and which PC it belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q    <= 1'b0;
            inflight_pc_q <= RESET_PC;
        end else begin
            inflight_q <= issue;
            if (issue) inflight_pc_q <= pc_i;
        end
    end

    assign resp_valid = inflight_q & ~redirect_i;
    assign resp       = '{inst: imem_rdata_i, pc: inflight_pc_q};

    // Decode view: queue head, or the arriving response when the queue is empty and bypass is built in.
    always_comb begin
        id_entry = head;
        id_valid = (count != '0);
        q_push   = resp_valid;
`ifdef FETCH_BYPASS_EN
        if (resp_valid && (count == '0)) begin
            id_entry = resp;
            id_valid = 1'b1;
            q_push   = ~id_ready_i;
        end
`endif
    end

    assign q_pop = id_ready_i & (count != '0);

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (redirect_i),
        .push_i      (q_push),
        .push_data_i (resp),
        .pop_i       (q_pop),
        .count_o     (count),
        .head_o      (head)
    );

    assign id_valid_o    = id_valid;
    assign id_inst_o     = id_entry.inst;
    assign id_pc_o       = id_entry.pc;
    assign id_pc_plus4_o = id_entry.pc + PC_STEP;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed table-driven bench for fetch_stage
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc_reg;
    logic [31:0] next_pc_o;
    logic        imem_en_o;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        id_ready = 1'b0;
    logic        id_valid_o;
    logic [31:0] id_inst_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_pc_plus4_o;

    int checks = 0;
    int errors = 0;

    fetch_stage #(.RESET_PC(RESET_PC), .DEPTH(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_i          (pc_reg),
        .next_pc_o     (next_pc_o),
        .imem_en_o     (imem_en_o),
        .imem_addr_o   (imem_addr_o),
        .imem_rdata_i  (imem_rdata),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .id_ready_i    (id_ready),
        .id_valid_o    (id_valid_o),
        .id_inst_o     (id_inst_o),
        .id_pc_o       (id_pc_o),
        .id_pc_plus4_o (id_pc_plus4_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hD000_0000 ^ (a >> 2);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_reg <= RESET_PC;
        else        pc_reg <= next_pc_o;
    end

    always @(posedge clk) begin
        if (imem_en_o) imem_rdata <= mem_word(imem_addr_o);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic rd, input logic [31:0] rpc);
        id_ready    = r;
        redirect    = rd;
        redirect_pc = rpc;
        @(negedge clk);
    endtask

    task automatic cyc(input logic r, input logic rd, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        drive(r, rd, rpc);
    endtask

    typedef struct {
        logic        ready;
        logic        redir;
        logic [31:0] rpc;
        logic        en;
        logic [31:0] npc;
        logic        v_nb;
        logic [31:0] pc_nb;
        logic        v_bp;
        logic [31:0] pc_bp;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic rd, input logic [31:0] rpc,
                                input logic en, input logic [31:0] npc,
                                input logic vn, input logic [31:0] pn,
                                input logic vb, input logic [31:0] pb);
        vec_t v;
        v = '{r, rd, rpc, en, npc, vn, pn, vb, pb};
        return v;
    endfunction

    vec_t tbl [13];

    initial begin
        logic        ev;
        logic [31:0] ep;
        logic [31:0] h;
        logic        found;
        int          first_en;
        int          first_v;

        // cycle 0 is the BOOT cycle after reset release
        tbl[0]  = mk(1, 0, 0,      0, 32'd0,     0, 0,      0, 0);
        tbl[1]  = mk(1, 0, 0,      1, 32'd4,     0, 0,      0, 0);
        tbl[2]  = mk(1, 0, 0,      1, 32'd8,     0, 0,      1, 32'd0);
        tbl[3]  = mk(1, 0, 0,      1, 32'd12,    1, 32'd0,  1, 32'd4);
        tbl[4]  = mk(1, 0, 0,      1, 32'd16,    1, 32'd4,  1, 32'd8);
        tbl[5]  = mk(1, 0, 0,      1, 32'd20,    1, 32'd8,  1, 32'd12);
        tbl[6]  = mk(1, 0, 0,      1, 32'd24,    1, 32'd12, 1, 32'd16);
        tbl[7]  = mk(1, 0, 0,      1, 32'd28,    1, 32'd16, 1, 32'd20);
        tbl[8]  = mk(1, 1, 'h100,  0, 32'h100,   1, 32'd20, 0, 0);
        tbl[9]  = mk(1, 0, 0,      1, 32'h104,   0, 0,      0, 0);
        tbl[10] = mk(1, 0, 0,      1, 32'h108,   0, 0,      1, 32'h100);
        tbl[11] = mk(1, 0, 0,      1, 32'h10C,   1, 32'h100, 1, 32'h104);
        tbl[12] = mk(1, 0, 0,      1, 32'h110,   1, 32'h104, 1, 32'h108);

        // held in reset
        @(negedge clk);
        chk("rst_valid", id_valid_o, 0);
        chk("rst_en", imem_en_o, 0);
        chk("rst_npc", next_pc_o, pc_reg);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            drive(tbl[i].ready, tbl[i].redir, tbl[i].rpc);
            ev = BYPASS ? tbl[i].v_bp : tbl[i].v_nb;
            ep = BYPASS ? tbl[i].pc_bp : tbl[i].pc_nb;
            chk($sformatf("t%0d_en", i), imem_en_o, tbl[i].en);
            chk($sformatf("t%0d_npc", i), next_pc_o, tbl[i].npc);
            chk($sformatf("t%0d_addr", i), imem_addr_o, pc_reg);
            chk($sformatf("t%0d_valid", i), id_valid_o, ev);
            if (ev) begin
                chk($sformatf("t%0d_pc", i), id_pc_o, ep);
                chk($sformatf("t%0d_inst", i), id_inst_o, mem_word(ep));
                chk($sformatf("t%0d_pc4", i), id_pc_plus4_o, ep + 32'd4);
            end
            if (i == 0) begin
                chk("rst_inst", id_inst_o, 32'h0000_0013);
                chk("rst_pc", id_pc_o, 32'h0);
                chk("rst_pc4", id_pc_plus4_o, 32'h4);
            end
        end

        // stall for 5 cycles: head stable, PC frozen once full
        h = 32'hx;
        for (int s = 0; s < 5; s++) begin
            cyc(0, 0, 0);
            chk($sformatf("stall%0d_valid", s), id_valid_o, 1);
            if (s == 0) h = id_pc_o;
            else        chk($sformatf("stall%0d_head", s), id_pc_o, h);
            if (s >= 2) begin
                chk($sformatf("stall%0d_en", s), imem_en_o, 0);
                chk($sformatf("stall%0d_hold", s), next_pc_o, pc_reg);
            end
        end
        for (int j = 0; j < 6; j++) begin
            cyc(1, 0, 0);
            chk($sformatf("resume%0d_valid", j), id_valid_o, 1);
            chk($sformatf("resume%0d_pc", j), id_pc_o, h + 32'(4 * j));
            chk($sformatf("resume%0d_inst", j), id_inst_o, mem_word(h + 32'(4 * j)));
        end

        // PC wrap at the top of the address space
        cyc(1, 1, 32'hFFFF_FFFC);
        cyc(1, 0, 0);
        chk("wrap_pc", pc_reg, 32'hFFFF_FFFC);
        chk("wrap_en", imem_en_o, 1);
        chk("wrap_npc", next_pc_o, 32'h0);
        found = 1'b0;
        for (int k = 0; k < 8 && !found; k++) begin
            if (id_valid_o && id_pc_o == 32'hFFFF_FFFC) begin
                found = 1'b1;
                chk("wrap_pc4", id_pc_plus4_o, 32'h0);
                chk("wrap_inst", id_inst_o, mem_word(32'hFFFF_FFFC));
            end else begin
                cyc(1, 0, 0);
            end
        end
        chk("wrap_seen", found, 1);

        // redirect while the queue is full
        for (int s = 0; s < 4; s++) cyc(0, 0, 0);
        chk("full_valid", id_valid_o, 1);
        cyc(0, 1, 32'h200);
        cyc(0, 0, 0);
        chk("redir_flush_valid", id_valid_o, 0);
        found = 1'b0;
        for (int k = 0; k < 8 && !found; k++) begin
            cyc(1, 0, 0);
            if (id_valid_o) begin
                found = 1'b1;
                chk("redir_first_pc", id_pc_o, 32'h200);
            end
        end
        chk("redir_seen", found, 1);

        // reset while full
        for (int s = 0; s < 4; s++) cyc(0, 0, 0);
        chk("prerst_valid", id_valid_o, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", id_valid_o, 0);
        chk("midrst_en", imem_en_o, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1, 0, 0);
        chk("reboot_en", imem_en_o, 0);
        chk("reboot_npc", next_pc_o, RESET_PC);
        chk("reboot_valid", id_valid_o, 0);

        // latency of the first fetch after an empty queue
        first_en = -1;
        first_v  = -1;
        for (int k = 1; k <= 8; k++) begin
            cyc(1, 0, 0);
            if (imem_en_o && first_en < 0) begin
                first_en = k;
                chk("restart_addr", imem_addr_o, RESET_PC);
            end
            if (id_valid_o && first_v < 0) begin
                first_v = k;
                chk("restart_pc", id_pc_o, RESET_PC);
            end
        end
        chk("restart_en_cycle", first_en, 1);
        chk("latency", first_v - first_en, BYPASS ? 1 : 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1);
    end

endmodule
